// File: rtl/join_pkt_injector_pkg.sv
// ---------------------------------------------------------------------------
// join_pkt_injector_pkg
// Shared constants and types for the JOIN packet injector.
//   PACKET_SIZE   : width of a JOIN packet
//   inj_state_e   : handshake FSM state encoding
// ---------------------------------------------------------------------------
package join_pkt_injector_pkg;

    localparam int PACKET_SIZE = 38;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } inj_state_e;

endpackage

// File: rtl/join_pkt_injector_if.sv
// ---------------------------------------------------------------------------
// join_pkt_injector_if
// Bundles the clocked write port and the self-timed JOIN input port group.
//   wr_valid / wr_packet / wr_ready : clocked enqueue handshake
//   Send_out / PACKET_OUT / Ack_in  : 4-phase RTZ handshake toward JOIN
// Modports:
//   slave  : the injector's view
//   master : the environment's view (loader + JOIN)
// ---------------------------------------------------------------------------
interface join_pkt_injector_if #(
    parameter int PKT_W = 38
) ();
    logic             wr_valid;
    logic [PKT_W-1:0] wr_packet;
    logic             wr_ready;
    logic             Send_out;
    logic [PKT_W-1:0] PACKET_OUT;
    logic             Ack_in;

    modport slave (
        input  wr_valid,
        input  wr_packet,
        input  Ack_in,
        output wr_ready,
        output Send_out,
        output PACKET_OUT
    );

    modport master (
        output wr_valid,
        output wr_packet,
        output Ack_in,
        input  wr_ready,
        input  Send_out,
        input  PACKET_OUT
    );
endinterface

// File: rtl/join_pkt_injector_inj_fifo.sv
// ---------------------------------------------------------------------------
// inj_fifo
// Synchronous FIFO buffering packets ahead of the JOIN handshake.
// Ports:
//   CP, MR_N   : clock, asynchronous active-low reset (flushes the FIFO)
//   push       : enqueue push_data (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   pop_data   : current head entry (no bypass: a push is visible next cycle)
//   full/empty : status from the pre-edge occupancy
//   level      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inj_fifo #(
    parameter int PKT_W = 38,
    parameter int DEPTH = 8
) (
    input  logic                     CP,
    input  logic                     MR_N,
    input  logic                     push,
    input  logic [PKT_W-1:0]         push_data,
    input  logic                     pop,
    output logic [PKT_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the pointers alone define valid contents.
    always_ff @(posedge CP) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/join_pkt_injector.sv
// ---------------------------------------------------------------------------
// join_pkt_injector
// Clocked source feeding packets into the self-timed JOIN pipeline input.
// Packets written on the clocked side are buffered in inj_fifo and driven out
// one at a time with a 4-phase return-to-zero Send/Ack handshake. Ack_in is
// asynchronous and is brought into the CP domain through SYNC_STAGES flops.
//
// Ports:
//   CP, MR_N   : clock, asynchronous active-low master reset
//   inj_if     : slave modport (wr_valid/wr_packet/wr_ready,
//                Send_out/PACKET_OUT/Ack_in)
//   level      : FIFO occupancy
//   busy       : FSM not idle or FIFO not empty
//   hs_timeout : sticky handshake watchdog flag
//
// Optional build macro JOIN_INJ_TIMEOUT_EN adds the handshake watchdog; when
// undefined, hs_timeout is tied low and no counter exists.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet in flight; waits for data with ack_s low
// SEND    | Send_out high, PACKET_OUT stable; waits for ack_s high
// RELEASE | Send_out low, PACKET_OUT held; waits for ack_s low
// ---------------------------------------------------------------------------
module join_pkt_injector
    import join_pkt_injector_pkg::*;
#(
    parameter int PKT_W       = PACKET_SIZE,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   CP,
    input  logic                   MR_N,
    join_pkt_injector_if.slave     inj_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   hs_timeout
);

    inj_state_e                 state_q, state_d;
    logic                       send_q, send_d;
    logic [PKT_W-1:0]           pkt_q, pkt_d;
    logic [SYNC_STAGES-1:0]     sync_q, sync_d;
    logic                       ack_s;
    logic                       load;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [PKT_W-1:0]           fifo_head;
    logic                       push;

    assign push = inj_if.wr_valid && !fifo_full;

    inj_fifo #(
        .PKT_W (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CP        (CP),
        .MR_N      (MR_N),
        .push      (push),
        .push_data (inj_if.wr_packet),
        .pop       (load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign ack_s = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], inj_if.Ack_in};

    assign inj_if.wr_ready   = !fifo_full;
    assign inj_if.Send_out   = send_q;
    assign inj_if.PACKET_OUT = pkt_q;
    assign busy              = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        pkt_d   = pkt_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A high ack_s (e.g. JOIN still acking at reset exit) blocks issue.
                if (!fifo_empty && !ack_s) begin
                    load = 1'b1;
                end
            end
            ST_SEND: begin
                if (ack_s) begin
                    state_d = ST_RELEASE;
                    send_d  = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                send_d  = 1'b0;
            end
        endcase
        // PACKET_OUT only changes here, on the way into SEND.
        if (load) begin
            pkt_d   = fifo_head;
            send_d  = 1'b1;
            state_d = ST_SEND;
        end
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= ST_IDLE;
            send_q  <= 1'b0;
            pkt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            pkt_q   <= pkt_d;
            sync_q  <= sync_d;
        end
    end

`ifdef JOIN_INJ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Down-counter reloaded on every SEND entry; reaching zero while a
    // handshake is outstanding trips the sticky flag.
    logic [TW-1:0] remain_q, remain_d;
    logic          hs_q, hs_d;

    always_comb begin
        remain_d = remain_q;
        hs_d     = hs_q;
        if (load) begin
            remain_d = TW'(TIMEOUT_CYC);
        end else if (state_q != ST_IDLE && remain_q != '0) begin
            remain_d = remain_q - TW'(1);
            if (remain_q == TW'(1)) begin
                hs_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            remain_q <= '0;
            hs_q     <= 1'b0;
        end else begin
            remain_q <= remain_d;
            hs_q     <= hs_d;
        end
    end

    assign hs_timeout = hs_q;
`else
    assign hs_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_join_pkt_injector.sv
module tb_join_pkt_injector;
    import join_pkt_injector_pkg::*;

    localparam int PKT_W = PACKET_SIZE;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;
    localparam int LW    = $clog2(DEPTH);

    logic CP   = 1'b0;
    logic MR_N = 1'b0;
    always #5 CP = ~CP;

    join_pkt_injector_if #(.PKT_W(PKT_W)) bus ();

    logic [LW:0] level;
    logic        busy;
    logic        hs_timeout;

    join_pkt_injector #(
        .PKT_W       (PKT_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CP         (CP),
        .MR_N       (MR_N),
        .inj_if     (bus.slave),
        .level      (level),
        .busy       (busy),
        .hs_timeout (hs_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Ack source: manual or auto responder ----------------
    logic man_ack  = 1'b1;
    logic resp_en  = 1'b0;
    logic resp_ack = 1'b1;
    int   resp_cnt = 0;
    assign bus.Ack_in = resp_en ? resp_ack : man_ack;

    // JOIN-like responder: ack 5 cycles after Send rises, release 5 cycles
    // after Send falls.
    always @(negedge CP) begin
        if (!resp_en) begin
            resp_ack = man_ack;
            resp_cnt = 0;
        end else if (bus.Send_out && !resp_ack) begin
            resp_cnt++;
            if (resp_cnt == 5) begin resp_ack = 1'b1; resp_cnt = 0; end
        end else if (!bus.Send_out && resp_ack) begin
            resp_cnt++;
            if (resp_cnt == 5) begin resp_ack = 1'b0; resp_cnt = 0; end
        end else begin
            resp_cnt = 0;
        end
    end

    // ---------------- behavioural model ----------------
    logic [PKT_W-1:0] mq[$];
    logic             m_send  = 1'b0;
    logic [PKT_W-1:0] m_pkt   = '0;
    int               m_phase = 0;     // 0 idle, 1 send, 2 release
    logic [SYNC-1:0]  m_sync  = '0;
    int               m_cnt   = 0;
    logic             m_hs    = 1'b0;
    logic             m_ack_s, m_accept, m_load, m_active;

    always @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            mq.delete();
            m_send = 0; m_pkt = '0; m_phase = 0; m_sync = '0; m_cnt = 0; m_hs = 0;
        end else begin
            m_ack_s  = m_sync[SYNC-1];
            m_accept = bus.wr_valid && (mq.size() < DEPTH);
            m_active = (m_phase != 0);
            m_load   = 1'b0;
            m_sync   = {m_sync[SYNC-2:0], bus.Ack_in};
            if (m_phase == 0) begin
                m_load = (mq.size() > 0) && !m_ack_s;
            end else if (m_phase == 1) begin
                if (m_ack_s) begin m_send = 0; m_phase = 2; end
            end else begin
                if (!m_ack_s) begin
                    if (mq.size() > 0) m_load = 1'b1;
                    else m_phase = 0;
                end
            end
            if (m_load) m_cnt = 0;
            else if (m_active) begin
                m_cnt++;
                if (m_cnt == TMO) m_hs = 1'b1;
            end
            if (m_load) begin
                m_pkt = mq.pop_front();
                m_send = 1; m_phase = 1;
            end
            if (m_accept) mq.push_back(bus.wr_packet);
        end
    end

    function automatic logic exp_hs();
`ifdef JOIN_INJ_TIMEOUT_EN
        return m_hs;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- compare + JOIN-side monitor ----------------
    logic             chk_en    = 1'b0;
    logic             prev_send = 1'b0;
    logic [PKT_W-1:0] held      = '0;
    logic [PKT_W-1:0] dut_log[$];

    always @(negedge CP) begin
        if (chk_en) begin
            chk("send_out",   bus.Send_out,   m_send);
            chk("packet_out", bus.PACKET_OUT, m_pkt);
            chk("level",      level,          mq.size());
            chk("wr_ready",   bus.wr_ready,   mq.size() < DEPTH);
            chk("busy",       busy,           (m_phase != 0) || (mq.size() != 0));
            chk("hs_timeout", hs_timeout,     exp_hs());
            if (bus.Send_out && !prev_send) begin
                dut_log.push_back(bus.PACKET_OUT);
                held = bus.PACKET_OUT;
            end else if (bus.Send_out && prev_send) begin
                chk("pkt_stable", bus.PACKET_OUT, held);
            end
            prev_send = bus.Send_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic wr(input logic [PKT_W-1:0] p);
        bus.wr_valid  = 1'b1;
        bus.wr_packet = p;
        tick();
        bus.wr_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int i;
        for (i = 0; i < max && !(busy == 1'b0 && bus.Send_out == 1'b0); i++) tick();
        chk(name, (busy == 1'b0 && bus.Send_out == 1'b0), 1);
    endtask

    task automatic wait_send_low(input int max, input string name);
        int i;
        for (i = 0; i < max && bus.Send_out; i++) tick();
        chk(name, bus.Send_out, 0);
    endtask

    localparam logic [PKT_W-1:0] X  = 38'h0_1234_5678;
    localparam logic [PKT_W-1:0] PA = 38'h2A_DEAD_BEEF;
    localparam logic [PKT_W-1:0] PB = 38'h15_CAFE_0001;
    localparam logic [PKT_W-1:0] PC = 38'h00_0000_0003;
    localparam logic [PKT_W-1:0] PBASE = 38'h10_0000_0000;
    localparam logic [PKT_W-1:0] QBASE = 38'h20_0000_0000;

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_packet = '0;
        man_ack = 1'b1;
        resp_en = 1'b0;
        MR_N    = 1'b0;
        repeat (3) tick();
        chk("rst_send",     bus.Send_out,   0);
        chk("rst_packet",   bus.PACKET_OUT, 0);
        chk("rst_level",    level,          0);
        chk("rst_wr_ready", bus.wr_ready,   1);
        chk("rst_busy",     busy,           0);
        chk("rst_hs",       hs_timeout,     0);
        chk_en = 1'b1;

        // T1: Ack_in high at reset exit blocks issue until it drops.
        MR_N = 1'b1;
        repeat (4) tick();
        wr(X);
        chk("t1_level", level, 1);
        repeat (5) tick();
        chk("t1_hold", bus.Send_out, 0);
        man_ack = 1'b0;
        tick(); chk("t1_e1", bus.Send_out, 0);
        tick(); chk("t1_e2", bus.Send_out, 0);
        tick(); chk("t1_e3_send", bus.Send_out, 1);
        chk("t1_e3_pkt", bus.PACKET_OUT, X);
        resp_en = 1'b1;
        wait_idle(200, "t1_idle_timeout");

        // T2: three packets through the responder, in order.
        dut_log.delete();
        wr(PA); wr(PB); wr(PC);
        wait_idle(300, "t2_idle_timeout");
        chk("t2_count", dut_log.size(), 3);
        if (dut_log.size() == 3) begin
            chk("t2_a", dut_log[0], PA);
            chk("t2_b", dut_log[1], PB);
            chk("t2_c", dut_log[2], PC);
        end
        chk("t2_busy", busy, 0);

        // T3: fill to full with Ack held low; 10th write dropped.
        resp_en = 1'b0;
        man_ack = 1'b0;
        tick();
        dut_log.delete();
        for (int i = 0; i < 8; i++) wr(PBASE + PKT_W'(i));
        chk("t3_level7",  level,        7);
        chk("t3_ready7",  bus.wr_ready, 1);
        wr(PBASE + PKT_W'(8));
        chk("t3_level8",  level,        8);
        chk("t3_ready8",  bus.wr_ready, 0);
        wr(PBASE + PKT_W'(9));
        chk("t3_drop",    level,        8);
        resp_en = 1'b1;
        wait_idle(1000, "t3_idle_timeout");
        chk("t3_count", dut_log.size(), 9);
        for (int i = 0; i < 9 && i < dut_log.size(); i++)
            chk("t3_data", dut_log[i], PBASE + PKT_W'(i));

        // T4: write coincides with the RELEASE->SEND pop at level 3.
        resp_en = 1'b0;
        man_ack = 1'b0;
        tick();
        dut_log.delete();
        for (int i = 0; i < 4; i++) wr(QBASE + PKT_W'(i));
        chk("t4_level3", level, 3);
        chk("t4_send",   bus.Send_out, 1);
        chk("t4_pkt0",   bus.PACKET_OUT, QBASE);
        man_ack = 1'b1;
        wait_send_low(20, "t4_fall_timeout");
        man_ack = 1'b0;
        tick(); tick();
        wr(QBASE + PKT_W'(4));
        chk("t4_level_same", level, 3);
        chk("t4_send2",      bus.Send_out, 1);
        chk("t4_pkt1",       bus.PACKET_OUT, QBASE + PKT_W'(1));
        resp_en = 1'b1;
        wait_idle(500, "t4_idle_timeout");
        chk("t4_count", dut_log.size(), 5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            chk("t4_data", dut_log[i], QBASE + PKT_W'(i));

        // T5: reset in SEND with level 4.
        resp_en = 1'b0;
        man_ack = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) wr(PBASE + PKT_W'(32 + i));
        chk("t5_level4", level, 4);
        chk("t5_send",   bus.Send_out, 1);
        #1 MR_N = 1'b0;
        #1;
        chk("t5_rst_send",  bus.Send_out,   0);
        chk("t5_rst_level", level,          0);
        chk("t5_rst_pkt",   bus.PACKET_OUT, 0);
        chk("t5_rst_ready", bus.wr_ready,   1);
        dut_log.delete();
        repeat (2) tick();
        MR_N = 1'b1;
        repeat (20) tick();
        chk("t5_no_send", dut_log.size(), 0);
        chk("t5_busy",    busy, 0);

        // T6: watchdog.
        MR_N = 1'b0;
        repeat (2) tick();
        MR_N = 1'b1;
        repeat (3) tick();
        wr(PA);
        tick();
        chk("t6_send", bus.Send_out, 1);
        repeat (15) tick();
        chk("t6_hs_15", hs_timeout, 0);
        tick();
`ifdef JOIN_INJ_TIMEOUT_EN
        chk("t6_hs_16", hs_timeout, 1);
`else
        chk("t6_hs_16", hs_timeout, 0);
`endif
        repeat (10) tick();
        resp_en = 1'b1;
        wait_idle(200, "t6_idle_timeout");
`ifdef JOIN_INJ_TIMEOUT_EN
        chk("t6_hs_sticky", hs_timeout, 1);
`else
        chk("t6_hs_tied", hs_timeout, 0);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/join_pkt_injector.md
Name: join_pkt_injector

Overview:
- Clocked source that feeds 38-bit packets into the self-timed JOIN pipeline's external input (its Send_in / PACKET_IN / Ack_out port group).
- Buffers packets written by clocked logic (testbench loader, host bus) in a small FIFO.
- Drives each packet out with a 4-phase return-to-zero Send/Ack handshake.
- Synchronizes the asynchronous Ack from JOIN into the CP domain.

Parameters:
- PKT_W, 38, packet width; must equal JOIN packet width.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2, flip-flop stages on Ack_in; at least 2.
- TIMEOUT_CYC, 1024, handshake watchdog limit; used only with the optional feature.

Ports:
- CP  in  1  clock.
- MR_N  in  1  master reset, asynchronous, active-low.
- wr_valid  in  1  write request.
- wr_packet  in  PKT_W  packet to enqueue.
- wr_ready  out  1  FIFO can accept; equals !full.
- Send_out  out  1  to JOIN Send_in; request.
- PACKET_OUT  out  PKT_W  to JOIN PACKET_IN.
- Ack_in  in  1  from JOIN Ack_out; asynchronous.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high when FSM is not IDLE or level != 0.
- hs_timeout  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:
- Reset: CP is the only clock. MR_N is asynchronous and active-low. While MR_N=0:
  - Send_out=0, PACKET_OUT=0, level=0, busy=0, hs_timeout=0.
  - wr_ready=1 (FIFO empty).
  - FSM=IDLE, sync chain cleared to 0.
- Write: accepted at a CP edge when wr_valid and wr_ready are both 1. No bypass path; a written packet becomes visible to the FSM on the following edge.
- ack_s is Ack_in after SYNC_STAGES flip-flops.
- FSM states:
  - IDLE: if level != 0 and ack_s == 0, load PACKET_OUT from the FIFO head, pop the FIFO, and go to SEND. If ack_s is still high (for example Ack_in high at reset exit), stay in IDLE.
  - SEND: Send_out=1 and PACKET_OUT stable. When ack_s == 1, go to RELEASE.
  - RELEASE: Send_out=0 and PACKET_OUT held. When ack_s == 0:
    - if level != 0, load and pop the next packet and go directly to SEND;
    - otherwise go to IDLE.
- Send_out is a registered decode of the state; it is glitch-free.
- PACKET_OUT changes only on the transition into SEND. It is stable from the Send_out rise until ack_s falls.
- Latency: a write at edge k raises Send_out after edge k+1 if the FSM is IDLE with ack_s=0. An Ack_in rise is seen in ack_s after SYNC_STAGES edges; Send_out falls one edge later.
- Simultaneous write and pop in the same edge: allowed when not full; level is unchanged.
- When full: wr_ready=0 and writes are ignored, including on the edge where a pop occurs (wr_ready is based on the pre-edge state).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (level == DEPTH).
- Reset mid-handshake: Send_out drops immediately and the FIFO is flushed. After MR_N deasserts, no Send is issued until ack_s reads 0.

Optional Feature:
- Macro JOIN_INJ_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to SEND and counts in SEND and RELEASE. When it reaches TIMEOUT_CYC, hs_timeout is set. It stays set until MR_N; the handshake continues normally.
- Undefined: no counter is built; hs_timeout is tied to 0.

Decomposition:
- Add `PACKET_SIZE (38) and the FSM state encodings (IDLE=2'd0, SEND=2'd1, RELEASE=2'd2) to macro.vh.
- One sub-module, inj_fifo: synchronous FIFO with DEPTH entries, asynchronous active-low reset, and push/pop/full/empty/level outputs.
- The Ack synchronizer stays inline.

Test Plan:
- Reset with Ack_in=1, release MR_N, write 38'h0_1234_5678 -> Send_out stays 0 until Ack_in is driven 0 and SYNC_STAGES+1 edges pass, then Send_out=1 and PACKET_OUT=38'h0_1234_5678.
- Write 3 packets A, B, C with a responder acking 5 cycles after Send rises and releasing 5 cycles after Send falls -> JOIN side sees A, B, C in order, each stable while Send_out=1, and busy returns to 0.
- Write 8 packets with Ack_in held 0 -> level=7 (one packet in the output register), wr_ready=1; write a 9th -> level=8, wr_ready=0; a 10th write is dropped; after the handshakes complete, exactly 9 packets are delivered.
- Write and pop on the same edge with level=3 -> level stays 3 and no data is lost or duplicated.
- Assert MR_N=0 while in SEND with level=4 -> Send_out=0, level=0 and PACKET_OUT=0 immediately; no packet is sent after release.
- With JOIN_INJ_TIMEOUT_EN, TIMEOUT_CYC=16, and Ack_in never rising -> hs_timeout=1 at cycle 16 after the Send rise and stays 1. Without the macro, hs_timeout=0 throughout.
